// File: rtl/coin_acceptor.sv
// Coin acceptor: accumulates coin credit, decides purchase/change/refund and
// offers a registered status code to a downstream vending FSM until it is acked.
module coin_acceptor #(
   parameter int PRICE      = 150,
   parameter int MAX_CREDIT = 250
) (
   input  logic       c,
   input  logic       r,
   input  logic       coin_valid,
   input  logic [1:0] coin_type,
   input  logic       cancel,
   input  logic       ack,
   output logic       e1,
   output logic       e2,
   output logic       valid,
   output logic [7:0] change,
   output logic [7:0] credit,
   output logic       coin_rej,
   output logic [1:0] dbg_state_o
);

   // Handshake: valid with {e1,e2}/change is held stable while in OFFER until ack
   // is sampled high; the transfer completes on that edge and valid drops.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      CHECK = 2'd2,
      OFFER = 2'd3
   } state_t;

   localparam logic [8:0] PRICE_9 = 9'(PRICE);
   localparam logic [8:0] MAX_9   = 9'(MAX_CREDIT);

   state_t     state_q, state_d;
   logic [7:0] credit_q, credit_d;
   logic [7:0] change_q, change_d;
   logic [1:0] code_q, code_d;
   logic       valid_q, valid_d;
   logic       rej_q, rej_d;

   logic [8:0] coin_val;
   logic       coin_legal;
   logic [8:0] sum_9;
   logic [7:0] over_price;
   logic       fits;

   always_comb begin
      coin_val   = 9'd0;
      coin_legal = 1'b1;
      case (coin_type)
         2'b00:   coin_val = 9'd25;
         2'b01:   coin_val = 9'd50;
         2'b10:   coin_val = 9'd100;
         default: coin_legal = 1'b0;
      endcase
   end

   // Sum at 9 bits so a coin that would overflow the 8-bit credit is rejected.
   assign sum_9      = {1'b0, credit_q} + coin_val;
   assign fits       = coin_legal && (sum_9 <= MAX_9);
   assign over_price = credit_q - PRICE_9[7:0];

   always_comb begin
      state_d  = state_q;
      credit_d = credit_q;
      change_d = change_q;
      code_d   = code_q;
      valid_d  = valid_q;
      rej_d    = 1'b0;
      case (state_q)
         IDLE, ACCUM: begin
            if ((state_q == ACCUM) && cancel) begin
               state_d  = OFFER;
               code_d   = 2'b01;
               change_d = credit_q;
               valid_d  = 1'b1;
               rej_d    = coin_valid;
            end else if (coin_valid) begin
               if (fits) begin
                  credit_d = sum_9[7:0];
                  state_d  = CHECK;
               end else begin
                  rej_d = 1'b1;
               end
            end
         end
         CHECK: begin
            rej_d = coin_valid;
            if ({1'b0, credit_q} >= PRICE_9) begin
               state_d  = OFFER;
               change_d = over_price;
               code_d   = (over_price == 8'd0) ? 2'b10 : 2'b11;
               valid_d  = 1'b1;
            end else begin
               state_d = ACCUM;
            end
         end
         OFFER: begin
            rej_d = coin_valid;
            if (ack) begin
               state_d  = IDLE;
               credit_d = 8'd0;
               change_d = 8'd0;
               code_d   = 2'b00;
               valid_d  = 1'b0;
            end
         end
         default: begin
            state_d  = IDLE;
            credit_d = 8'd0;
            change_d = 8'd0;
            code_d   = 2'b00;
            valid_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge c or negedge r) begin
      if (!r) begin
         state_q  <= IDLE;
         credit_q <= 8'd0;
         change_q <= 8'd0;
         code_q   <= 2'b00;
         valid_q  <= 1'b0;
         rej_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         credit_q <= credit_d;
         change_q <= change_d;
         code_q   <= code_d;
         valid_q  <= valid_d;
         rej_q    <= rej_d;
      end
   end

   assign e1          = code_q[1];
   assign e2          = code_q[0];
   assign valid       = valid_q;
   assign change      = change_q;
   assign credit      = credit_q;
   assign coin_rej    = rej_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor: a default-parameter instance for the main
// flows and a small-credit instance for the overflow rejection case.
module tb_coin_acceptor;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ACCUM = 2'd1;
   localparam logic [1:0] S_CHECK = 2'd2;
   localparam logic [1:0] S_OFFER = 2'd3;

   logic       c = 1'b0;
   logic       r = 1'b0;
   logic       coin_valid = 1'b0;
   logic [1:0] coin_type = 2'b00;
   logic       cancel = 1'b0;
   logic       ack = 1'b0;
   logic       e1, e2, valid, coin_rej;
   logic [7:0] change, credit;
   logic [1:0] state;

   logic       coin_valid2 = 1'b0;
   logic [1:0] coin_type2 = 2'b00;
   logic       cancel2 = 1'b0;
   logic       ack2 = 1'b0;
   logic       e1_2, e2_2, valid2, coin_rej2;
   logic [7:0] change2, credit2;
   logic [1:0] state2;

   int total = 0;
   int bad = 0;

   always #5 c = ~c;

   coin_acceptor u_dut (
      .c(c), .r(r), .coin_valid(coin_valid), .coin_type(coin_type),
      .cancel(cancel), .ack(ack), .e1(e1), .e2(e2), .valid(valid),
      .change(change), .credit(credit), .coin_rej(coin_rej), .dbg_state_o(state)
   );

   coin_acceptor #(.PRICE(200), .MAX_CREDIT(100)) u_dut2 (
      .c(c), .r(r), .coin_valid(coin_valid2), .coin_type(coin_type2),
      .cancel(cancel2), .ack(ack2), .e1(e1_2), .e2(e2_2), .valid(valid2),
      .change(change2), .credit(credit2), .coin_rej(coin_rej2), .dbg_state_o(state2)
   );

   task automatic step();
      @(posedge c);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_offer(input string tag, input logic [1:0] code, input logic [7:0] chg,
                            input logic [7:0] cred);
      chk({tag, "_state"}, 32'(state), 32'(S_OFFER));
      chk({tag, "_valid"}, 32'(valid), 32'd1);
      chk({tag, "_code"}, 32'({e1, e2}), 32'(code));
      chk({tag, "_change"}, 32'(change), 32'(chg));
      chk({tag, "_credit"}, 32'(credit), 32'(cred));
   endtask

   task automatic coin(input logic [1:0] t);
      coin_valid = 1'b1;
      coin_type  = t;
      step();
      coin_valid = 1'b0;
   endtask

   initial begin
      // Reset values before any clock edge.
      #2;
      chk("rst_state", 32'(state), 32'(S_IDLE));
      chk("rst_credit", 32'(credit), 32'd0);
      chk("rst_outs", 32'({valid, e1, e2, coin_rej}), 32'd0);
      chk("rst_change", 32'(change), 32'd0);
      step();
      r = 1'b1;

      // Exact payment: 100 + 50; first coin on the first edge after release.
      coin(2'b10);
      chk("exact_c1_credit", 32'(credit), 32'd100);
      chk("exact_c1_state", 32'(state), 32'(S_CHECK));
      chk("exact_c1_valid", 32'(valid), 32'd0);
      step();
      chk("exact_accum", 32'(state), 32'(S_ACCUM));
      ack = 1'b1;
      coin(2'b01);
      ack = 1'b0;
      chk("exact_ack_ignored_credit", 32'(credit), 32'd150);
      chk("exact_check_valid", 32'(valid), 32'd0);
      step();
      chk_offer("exact", 2'b10, 8'd0, 8'd150);
      ack = 1'b1;
      step();
      ack = 1'b0;
      chk("exact_ack_state", 32'(state), 32'(S_IDLE));
      chk("exact_ack_credit", 32'(credit), 32'd0);
      chk("exact_ack_outs", 32'({valid, e1, e2}), 32'd0);

      // Cancel in IDLE does nothing.
      cancel = 1'b1;
      step();
      cancel = 1'b0;
      chk("idle_cancel_state", 32'(state), 32'(S_IDLE));
      chk("idle_cancel_valid", 32'(valid), 32'd0);

      // Overpay: 100 + 100 -> change 50, held without ack.
      coin(2'b10);
      step();
      coin(2'b10);
      chk("over_credit", 32'(credit), 32'd200);
      step();
      chk_offer("over", 2'b11, 8'd50, 8'd200);
      for (int i = 0; i < 5; i++) begin
         step();
         chk_offer("over_hold", 2'b11, 8'd50, 8'd200);
      end
      ack = 1'b1;
      step();
      ack = 1'b0;
      chk("over_ack_state", 32'(state), 32'(S_IDLE));

      // Cancel refund, then a coin while valid is rejected.
      coin(2'b01);
      step();
      cancel = 1'b1;
      step();
      cancel = 1'b0;
      chk_offer("cancel", 2'b01, 8'd50, 8'd50);
      coin(2'b00);
      chk("cancel_rej", 32'(coin_rej), 32'd1);
      chk("cancel_rej_credit", 32'(credit), 32'd50);
      chk("cancel_rej_hold", 32'({e1, e2}), 32'd1);
      step();
      chk("cancel_rej_pulse_end", 32'(coin_rej), 32'd0);
      ack = 1'b1;
      step();
      ack = 1'b0;

      // Invalid coin type.
      coin(2'b11);
      chk("bad_type_rej", 32'(coin_rej), 32'd1);
      chk("bad_type_credit", 32'(credit), 32'd0);
      chk("bad_type_state", 32'(state), 32'(S_IDLE));
      step();
      chk("bad_type_pulse_end", 32'(coin_rej), 32'd0);

      // Back-to-back strobes: the second lands in CHECK and is rejected.
      coin_valid = 1'b1;
      coin_type  = 2'b10;
      step();
      coin_type  = 2'b00;
      step();
      coin_valid = 1'b0;
      chk("check_rej", 32'(coin_rej), 32'd1);
      chk("check_rej_credit", 32'(credit), 32'd100);
      chk("check_rej_state", 32'(state), 32'(S_ACCUM));
      step();
      chk("check_rej_pulse_end", 32'(coin_rej), 32'd0);
      cancel = 1'b1;
      step();
      cancel = 1'b0;
      chk_offer("check_refund", 2'b01, 8'd100, 8'd100);
      ack = 1'b1;
      step();
      ack = 1'b0;

      // Collision: coin and cancel together in ACCUM.
      coin(2'b00);
      step();
      cancel     = 1'b1;
      coin_valid = 1'b1;
      coin_type  = 2'b01;
      step();
      cancel     = 1'b0;
      coin_valid = 1'b0;
      chk_offer("collide", 2'b01, 8'd25, 8'd25);
      chk("collide_rej", 32'(coin_rej), 32'd1);
      step();
      chk("collide_pulse_end", 32'(coin_rej), 32'd0);

      // Half-cycle reset while in OFFER.
      #2;
      r = 1'b0;
      #1;
      chk("midrst_state", 32'(state), 32'(S_IDLE));
      chk("midrst_credit", 32'(credit), 32'd0);
      chk("midrst_change", 32'(change), 32'd0);
      chk("midrst_outs", 32'({valid, e1, e2, coin_rej}), 32'd0);
      #4;
      r = 1'b1;
      coin_valid = 1'b1;
      coin_type  = 2'b10;
      step();
      coin_valid = 1'b0;
      chk("postrst_credit", 32'(credit), 32'd100);
      step();

      // Small-credit instance: 100 then 25 exceeds MAX_CREDIT=100.
      coin_valid2 = 1'b1;
      coin_type2  = 2'b10;
      step();
      coin_valid2 = 1'b0;
      chk("cap_c1_credit", 32'(credit2), 32'd100);
      step();
      chk("cap_accum", 32'(state2), 32'(S_ACCUM));
      coin_valid2 = 1'b1;
      coin_type2  = 2'b00;
      step();
      coin_valid2 = 1'b0;
      chk("cap_rej", 32'(coin_rej2), 32'd1);
      chk("cap_credit", 32'(credit2), 32'd100);
      chk("cap_valid", 32'({valid2, e1_2, e2_2}), 32'd0);
      chk("cap_change", 32'(change2), 32'd0);
      step();
      chk("cap_pulse_end", 32'(coin_rej2), 32'd0);
      chk("cap_state", 32'(state2), 32'(S_ACCUM));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
